// File: rtl/speaker_control.sv
`timescale 1ns/1ps
// speaker_control: stereo I2S transmitter for the Pmod I2S DAC.
// Derives MCLK (clk/4), SCK (clk/16) and LRCK (clk/512) from a free-running
// 9-bit counter. It latches one attenuated stereo sample per frame and shifts
// it out MSB-first with the standard I2S one-bit delay.
// Optional feature macro: SPK_SOFTMUTE_EN. When it is defined, mute ramps the
// attenuation one step every RAMP_FRAMES frames. When it is undefined, mute
// switches hard between full level and silence on the next frame.
module speaker_control #(
  parameter int RAMP_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_in_left,
  input  logic [15:0] audio_in_right,
  input  logic        mute,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_tick,
  output logic        muted
);

  localparam int          DATA_W    = 16;
  localparam logic [4:0]  ATTEN_MAX = 5'd16;
  localparam logic [8:0]  CNT_LAST  = 9'd511;

  if (RAMP_FRAMES < 1 || RAMP_FRAMES > 1023) begin : g_ramp_range_bad
    $error("speaker_control: RAMP_FRAMES must be in 1..1023");
  end

  // Arithmetic right shift by the attenuation amount; 16 or more means silence.
  function automatic logic signed [DATA_W-1:0] attenuate(
    input logic signed [DATA_W-1:0] x,
    input logic [4:0]               sh
  );
    if (sh >= ATTEN_MAX) begin
      return '0;
    end
    return x >>> sh;
  endfunction

  logic [8:0]               cnt;
  logic [31:0]              sr;
  logic [4:0]               atten;
  logic [4:0]               atten_nxt;
  logic                     frame_edge;
  logic                     bit_edge;
  logic signed [DATA_W-1:0] l_att;
  logic signed [DATA_W-1:0] r_att;

  // The frame-latch edge is the 511 -> 0 wrap. Every other SCK falling edge is a bit edge.
  assign frame_edge = (cnt == CNT_LAST);
  assign bit_edge   = (cnt[3:0] == 4'hF) && !frame_edge;

  // The clock outputs are plain counter taps, so they are glitch-free registered bits.
  assign audio_mclk = cnt[1];
  assign audio_sck  = cnt[3];
  assign audio_lrck = cnt[8];

  assign muted = (atten == ATTEN_MAX);

  // The words loaded on the latch edge use the attenuation that takes effect on
  // that same edge, so a mute shows up in the very next frame.
  assign l_att = attenuate($signed(audio_in_left),  atten_nxt);
  assign r_att = attenuate($signed(audio_in_right), atten_nxt);

`ifdef SPK_SOFTMUTE_EN
  localparam logic [9:0] RAMP_LAST = 10'(RAMP_FRAMES - 1);

  logic [9:0] ramp_cnt;
  logic [9:0] ramp_nxt;
  logic       mute_prev;

  // Ramp scheduler: a level change of mute restarts the frame count. Otherwise
  // atten moves one step toward its target every RAMP_FRAMES frames.
  always_comb begin
    atten_nxt = atten;
    ramp_nxt  = ramp_cnt;
    if (mute != mute_prev) begin
      ramp_nxt = '0;
    end else if (ramp_cnt >= RAMP_LAST) begin
      ramp_nxt = '0;
      if (mute && atten != ATTEN_MAX) begin
        atten_nxt = atten + 5'd1;
      end else if (!mute && atten != 5'd0) begin
        atten_nxt = atten - 5'd1;
      end
    end else begin
      ramp_nxt = ramp_cnt + 10'd1;
    end
  end

  // Ramp state advances only on frame-latch edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt  <= '0;
      mute_prev <= 1'b0;
    end else if (frame_edge) begin
      ramp_cnt  <= ramp_nxt;
      mute_prev <= mute;
    end
  end
`else
  // Hard mute: full silence or full level, chosen at each frame latch.
  always_comb begin
    atten_nxt = mute ? ATTEN_MAX : 5'd0;
  end
`endif

  // Free-running frame counter, wraps 511 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 9'd1;
    end
  end

  // Attenuation level is committed only on frame-latch edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atten <= '0;
    end else if (frame_edge) begin
      atten <= atten_nxt;
    end
  end

  // Shift register and serial output. On the latch edge the previous frame's
  // last bit (R0) goes out as the new word loads, which gives the I2S one-bit delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      audio_sdin <= 1'b0;
    end else if (frame_edge) begin
      audio_sdin <= sr[31];
      sr         <= {l_att, r_att};
    end else if (bit_edge) begin
      audio_sdin <= sr[31];
      sr         <= {sr[30:0], 1'b0};
    end
  end

  // One-clk strobe marking the frame latch for upstream sample producers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= frame_edge;
    end
  end

endmodule
